// File: rtl/systolic_drainer.sv
// rtl/systolic_drainer.sv - drains unary systolic-array lanes into per-lane binary counts
// SYST_DRAIN_DESKEW_EN: per-lane skewed capture windows; undefined: one common window
module systolic_drainer #(
   parameter  int DIM    = 8,
   parameter  int UWIDTH = 2,
   parameter  int WIN    = 8,
   localparam int ACCW   = $clog2(WIN*UWIDTH+1)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic [DIM-1:0][UWIDTH-1:0]  lane_in,
   output logic [DIM-1:0][ACCW-1:0]    row_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy
);

`ifdef SYST_DRAIN_DESKEW_EN
   localparam int CAP_LAST = WIN + DIM - 2;
`else
   localparam int CAP_LAST = WIN - 1;
`endif
   // cnt must also hold CAP_LAST+1, reached on the HOLD transition
   localparam int CNTW = $clog2(CAP_LAST + 2);

   typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

   state_t                    state, state_nxt;
   logic [CNTW-1:0]           cnt;
   logic [DIM-1:0][ACCW-1:0]  acc;
   logic [DIM-1:0][ACCW-1:0]  pop;
   logic [DIM-1:0]            lane_en;
   logic                      clear;
   logic                      capture;
   logic                      cap_done;

   assign cap_done = (cnt == CNTW'(CAP_LAST));

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = CAPTURE;
         CAPTURE: if (cap_done)  state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = start ? CAPTURE : IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      out_valid = 1'b0;
      clear     = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE:    clear = start;
         CAPTURE: begin
            busy    = 1'b1;
            capture = 1'b1;
         end
         HOLD: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            clear     = out_ready & start;
         end
         default: ;
      endcase
   end

`ifdef SYST_DRAIN_DESKEW_EN
   int cnt_i;
   assign cnt_i = int'(cnt);
`endif

   // Lane i sees its first valid unary word i cycles after lane 0 when deskewed
   always_comb begin
      for (int i = 0; i < DIM; i++) begin
         pop[i] = '0;
         for (int b = 0; b < UWIDTH; b++)
            pop[i] = pop[i] + ACCW'(lane_in[i][b]);
`ifdef SYST_DRAIN_DESKEW_EN
         lane_en[i] = (cnt_i >= i) && (cnt_i <= i + WIN - 1);
`else
         lane_en[i] = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
         acc <= '0;
      end else if (clear) begin
         cnt <= '0;
         acc <= '0;
      end else if (capture) begin
         cnt <= cnt + CNTW'(1);
         for (int i = 0; i < DIM; i++)
            if (lane_en[i])
               acc[i] <= acc[i] + pop[i];
      end
   end

   assign row_out = acc;

endmodule
